// File: rtl/ram_mmio_pkg.sv
// Shared constants for the cpuv2 memory target: register window size and offsets.
// cpu-side software headers mirror these values.
package ram_mmio_pkg;

    localparam int WIN_SIZE = 16;

    localparam logic [3:0] OFS_CNT0   = 4'd0;
    localparam logic [3:0] OFS_CNT1   = 4'd1;
    localparam logic [3:0] OFS_CNT2   = 4'd2;
    localparam logic [3:0] OFS_CNT3   = 4'd3;
    localparam logic [3:0] OFS_LEDS   = 4'd4;
    localparam logic [3:0] OFS_STATUS = 4'd5;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/ram_byte.sv
// Byte-wide simple dual-port RAM, read-first, no reset (maps onto block RAM).
module ram_byte #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/ram_mmio.sv
// cpuv2 memory target: byte RAM, 16-byte register window at the top of the
// address space (cycle counter, LEDs, status) and a post-reset clearing sweep.
module ram_mmio
    import ram_mmio_pkg::*;
#(
    parameter int addr_width     = 9,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [addr_width-1:0] mem_raddr,
    output logic [7:0]            mem_data_out,
    input  logic [addr_width-1:0] mem_waddr,
    input  logic [7:0]            mem_data_in,
    input  logic                  mem_write,
    output logic                  mem_ready,
    output logic [7:0]            leds
);

    localparam int unsigned           DEPTH    = 2**addr_width;
    localparam logic [addr_width-1:0] WIN_ADDR = addr_width'(DEPTH - WIN_SIZE);
    localparam logic [addr_width-1:0] WIN_LAST = addr_width'(DEPTH - WIN_SIZE - 1);

    sweep_state_t          state_q, state_d;
    logic [addr_width-1:0] ptr_q, ptr_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [23:0]           shadow_q, shadow_d;
    logic [7:0]            leds_q, leds_d;
    logic                  win_sel_q, win_sel_d;
    logic [7:0]            reg_rd_q, reg_rd_d;

    logic                  ready;
    logic                  rd_win, wr_win;
    logic [3:0]            rd_ofs;
    logic                  ram_we;
    logic [addr_width-1:0] ram_waddr;
    logic [7:0]            ram_wdata;
    logic [7:0]            ram_rdata;

    assign ready  = (state_q == ST_READY);
    assign rd_win = (mem_raddr >= WIN_ADDR);
    assign wr_win = (mem_waddr >= WIN_ADDR);
    // The window is 16-aligned, so the low nibble is the register offset.
    assign rd_ofs = mem_raddr[3:0];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q + 32'd1;
        shadow_d  = shadow_q;
        leds_d    = leds_q;
        win_sel_d = rd_win;
        reg_rd_d  = 8'h00;
        ram_we    = 1'b0;
        ram_waddr = mem_waddr;
        ram_wdata = mem_data_in;

        if (!ready) begin
            if (CLEAR_ON_RESET) begin
                ram_we    = 1'b1;
                ram_waddr = ptr_q;
                ram_wdata = 8'h00;
            end
            ptr_d = ptr_q + addr_width'(1);
            if (!CLEAR_ON_RESET || ptr_q == WIN_LAST) begin
                state_d = ST_READY;
            end
        end else if (mem_write) begin
            if (!wr_win) begin
                ram_we = 1'b1;
            end else if (mem_waddr[3:0] == OFS_LEDS) begin
                leds_d = mem_data_in;
            end
        end

        // Reading the top counter byte freezes the low 24 bits so a
        // byte-by-byte 32-bit read is coherent.
        if (rd_win) begin
            case (rd_ofs)
                OFS_CNT0: begin
                    reg_rd_d = cnt_q[31:24];
                    shadow_d = cnt_q[23:0];
                end
                OFS_CNT1:   reg_rd_d = shadow_q[23:16];
                OFS_CNT2:   reg_rd_d = shadow_q[15:8];
                OFS_CNT3:   reg_rd_d = shadow_q[7:0];
                OFS_LEDS:   reg_rd_d = leds_q;
                OFS_STATUS: reg_rd_d = {7'b0, ready};
                default:    reg_rd_d = 8'h00;
            endcase
        end
    end

    // Window select resets to 1 with zero register data so the output reads 0
    // in reset even though the RAM read port itself is not reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            ptr_q     <= '0;
            cnt_q     <= 32'd0;
            shadow_q  <= 24'd0;
            leds_q    <= 8'h00;
            win_sel_q <= 1'b1;
            reg_rd_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            leds_q    <= leds_d;
            win_sel_q <= win_sel_d;
            reg_rd_q  <= reg_rd_d;
        end
    end

    ram_byte #(
        .ADDR_W(addr_width)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (mem_raddr),
        .rdata (ram_rdata)
    );

    assign mem_data_out = win_sel_q ? reg_rd_q : ram_rdata;
    assign mem_ready    = ready;
    assign leds         = leds_q;

endmodule

// File: tb/tb_ram_mmio.sv
// Bench for ram_mmio: directed steps plus random traffic against a behavioural
// memory/register model keyed on clocks elapsed since reset release.
module tb_ram_mmio;

    localparam int AW    = 9;
    localparam int DEPTH = 512;
    localparam int WIN   = DEPTH - 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] mem_raddr = '0;
    logic [AW-1:0] mem_waddr = '0;
    logic [7:0]    mem_data_in = '0;
    logic          mem_write = 1'b0;
    logic [7:0]    mem_data_out;
    logic          mem_ready;
    logic [7:0]    leds;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_mmio #(
        .addr_width     (AW),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_raddr    (mem_raddr),
        .mem_data_out (mem_data_out),
        .mem_waddr    (mem_waddr),
        .mem_data_in  (mem_data_in),
        .mem_write    (mem_write),
        .mem_ready    (mem_ready),
        .leds         (leds)
    );

    // Reference model: clocks since release, counter offset after a poke,
    // RAM image (all zero once the sweep has run), shadow and LED registers.
    logic [31:0] m_edges;
    logic [31:0] cnt_ofs = '0;
    logic [7:0]  m_ram [0:WIN-1];
    logic [23:0] m_shadow = '0;
    logic [7:0]  m_leds = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) m_edges <= 32'd0;
        else       m_edges <= m_edges + 32'd1;
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_leds   = 8'h00;
        m_shadow = 24'd0;
        cnt_ofs  = 32'd0;
        for (int i = 0; i < WIN; i++) m_ram[i] = 8'h00;
    endtask

    // One bus cycle, entered and left at a falling edge.
    task automatic step(input logic [AW-1:0] ra, input bit we,
                        input logic [AW-1:0] wa, input logic [7:0] wd);
        logic [7:0]  exp;
        logic [31:0] c;
        bit          rdy;
        bit          chk;
        rdy = (m_edges >= WIN);
        c   = m_edges + cnt_ofs;
        chk = 1'b1;
        if (int'(ra) >= WIN) begin
            case (int'(ra) - WIN)
                0:       exp = c[31:24];
                1:       exp = m_shadow[23:16];
                2:       exp = m_shadow[15:8];
                3:       exp = m_shadow[7:0];
                4:       exp = m_leds;
                5:       exp = {7'b0, rdy};
                default: exp = 8'h00;
            endcase
            if (int'(ra) == WIN) m_shadow = c[23:0];
        end else begin
            exp = m_ram[ra];
            chk = rdy;
        end
        if (we && rdy) begin
            if (int'(wa) < WIN)           m_ram[wa] = wd;
            else if (int'(wa) == WIN + 4) m_leds = wd;
        end
        mem_raddr   = ra;
        mem_waddr   = wa;
        mem_data_in = wd;
        mem_write   = we;
        @(posedge clk);
        @(negedge clk);
        mem_write = 1'b0;
        if (chk) check8($sformatf("rd@%03h", ra), mem_data_out, exp);
        check8("leds", leds, m_leds);
        check8("ready", {7'b0, mem_ready}, {7'b0, (m_edges >= WIN)});
    endtask

    task automatic rd(input logic [AW-1:0] ra);
        step(ra, 1'b0, '0, 8'h00);
    endtask

    task automatic wr(input logic [AW-1:0] wa, input logic [7:0] wd);
        step(AW'(WIN + 6), 1'b1, wa, wd);
    endtask

    // Runs bus cycles until mem_ready rises, pokes the CPU write port during
    // the sweep, and checks the sweep length.
    task automatic sweep_and_count();
        int n;
        n = 0;
        while (!mem_ready && n < 1000) begin
            if (n == 10)      step(AW'(WIN + 5), 1'b1, 9'h020, 8'h77);
            else if (n == 20) step(AW'(WIN + 4), 1'b1, AW'(WIN + 4), 8'h99);
            else              step(AW'(WIN + $urandom_range(0, 15)), 1'b0, '0, 8'h00);
            n++;
        end
        check_int("sweep_len", n, WIN);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check8("rst_dout", mem_data_out, 8'h00);
        check8("rst_ready", {7'b0, mem_ready}, 8'h00);
        check8("rst_leds", leds, 8'h00);
        reset = 1'b0;

        sweep_and_count();
        rd(9'h000);
        rd(9'h1EF);
        rd(9'h020);
        rd(9'h1F5);
        check8("status_ready", mem_data_out, 8'h01);

        wr(9'h010, 8'hA5);
        rd(9'h010);
        check8("rd_a5", mem_data_out, 8'hA5);
        step(9'h010, 1'b1, 9'h010, 8'h3C);
        check8("read_first", mem_data_out, 8'hA5);
        rd(9'h010);
        check8("rd_3c", mem_data_out, 8'h3C);

        wr(9'h1F4, 8'h5A);
        check8("leds_5a", leds, 8'h5A);
        rd(9'h1F4);
        check8("leds_rb", mem_data_out, 8'h5A);
        wr(9'h1F6, 8'h11);
        rd(9'h1F6);
        check8("ofs6_rd", mem_data_out, 8'h00);

        dut.cnt_q = 32'h00FF_FFFF;
        cnt_ofs   = 32'h00FF_FFFF - m_edges;
        rd(9'h1F0);
        check8("cnt0", mem_data_out, 8'h00);
        rd(9'h1F1);
        check8("cnt1", mem_data_out, 8'hFF);
        rd(9'h1F2);
        check8("cnt2", mem_data_out, 8'hFF);
        rd(9'h1F3);
        check8("cnt3", mem_data_out, 8'hFF);

        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] ra;
            logic [AW-1:0] wa;
            ra = ($urandom_range(0, 3) == 0) ? AW'(WIN + $urandom_range(0, 15))
                                             : AW'($urandom_range(0, 31));
            wa = ($urandom_range(0, 3) == 0) ? AW'(WIN + $urandom_range(0, 15))
                                             : AW'($urandom_range(0, 31));
            step(ra, 1'($urandom_range(0, 1)), wa, 8'($urandom));
        end

        wr(9'h1F4, 8'hC3);
        #2 reset = 1'b1;
        #1;
        check8("async_ready", {7'b0, mem_ready}, 8'h00);
        check8("async_leds", leds, 8'h00);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 200; i++) rd(AW'(WIN + 5));
        #2 reset = 1'b1;
        #1;
        check8("mid_ready", {7'b0, mem_ready}, 8'h00);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        sweep_and_count();
        rd(9'h020);
        rd(9'h010);
        check8("cleared_010", mem_data_out, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
